shake128_block_packer: RTL and testbench

Message-side front end for the pipelined SHAKE128 core. Accepts a 64-bit little-endian message word stream, packs it into RATE-bit blocks and applies SHAKE padding: domain byte 0x1F after the last message byte, and 0x80 XORed into the final rate byte. Each finished block is presented on a valid/ready port that connects directly to the core's `in_valid`/`in_block`/`in_last`/`in_ready` absorb interface.

---
 rtl/shake128_block_packer.sv | 180 ++++++++++++++++++
 tb/tb_shake128_block_packer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shake128_block_packer.sv
// shake128_block_packer
// Packs a 64-bit little-endian message word stream into RATE-bit blocks
// with SHAKE padding, for the absorb port of the SHAKE128 core.
// Build option: define SHAKE_PACK_SHA3_DS_EN to use the SHA3 domain byte
// 0x06 in place of the SHAKE domain byte 0x1F. Interface and timing are
// the same either way.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FILL  | accepting message words into the accumulator
// ST_EMIT  | accumulator presented as a block, waiting for blk_ready
// ST_EXTRA | pad-only block presented (message ended on a block edge)

module shake128_block_packer #(
  parameter int RATE = 1344
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            init,
  input  logic            msg_valid,
  input  logic [63:0]     msg_data,
  input  logic            msg_last,
  input  logic [3:0]      msg_bytes,
  output logic            msg_ready,
  output logic            blk_valid,
  output logic [RATE-1:0] blk_data,
  output logic            blk_last,
  input  logic            blk_ready,
  output logic            busy
);

  localparam int LANES = RATE / 64;
  localparam int BYTES = RATE / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW    = $clog2(BYTES + 1);

  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

`ifdef SHAKE_PACK_SHA3_DS_EN
  localparam logic [7:0] DS_BYTE = 8'h06;
`else
  localparam logic [7:0] DS_BYTE = 8'h1F;
`endif

  // Pad-only block: domain byte first, 0x80 in the final rate byte.
  localparam logic [RATE-1:0] EXTRA_BLK = {{(RATE-8){1'b0}}, DS_BYTE} |
                                          {8'h80, {(RATE-8){1'b0}}};

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_EXTRA = 2'd2
  } state_t;

  state_t          state_q,    state_d;
  logic [RATE-1:0] acc_q,      acc_d;
  logic [LW-1:0]   lane_cnt_q, lane_cnt_d;
  logic            pad_pend_q, pad_pend_d;
  logic            last_q,     last_d;

  logic [3:0]      n_eff;
  logic [63:0]     lane_word;
  logic [PW-1:0]   pad_byte;
  logic [RATE-1:0] pad_vec;
  logic            full_tail;

  // Shape the incoming word: clamp the byte count, zero bytes past the
  // end of the message, and build the padding pattern for this position.
  always_comb begin : word_prep
    n_eff     = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    lane_word = msg_data;
    if (msg_last) begin
      for (int k = 0; k < 8; k++) begin
        if (4'(k) >= n_eff) begin
          lane_word[8*k +: 8] = 8'h00;
        end
      end
    end
    // With n=8 this lands on the first byte of the next lane, which is
    // exactly where the domain byte belongs.
    pad_byte = PW'({lane_cnt_q, 3'b000}) + PW'(n_eff);
    pad_vec  = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (PW'(b) == pad_byte) begin
        pad_vec[8*b +: 8] = DS_BYTE;
      end
    end
    pad_vec[RATE-8 +: 8] = pad_vec[RATE-8 +: 8] ^ 8'h80;
    // A full final word in the last lane leaves no room for padding.
    full_tail = msg_last && (n_eff == 4'd8) && (lane_cnt_q == LAST_LANE);
  end

  // Next-state and accumulator update; init overrides everything.
  always_comb begin : fsm_next
    state_d    = state_q;
    acc_d      = acc_q;
    lane_cnt_d = lane_cnt_q;
    pad_pend_d = pad_pend_q;
    last_d     = last_q;

    unique case (state_q)
      ST_FILL: begin
        if (msg_valid) begin
          for (int i = 0; i < LANES; i++) begin
            if (LW'(i) == lane_cnt_q) begin
              acc_d[64*i +: 64] = lane_word;
            end
          end
          if (msg_last) begin
            state_d = ST_EMIT;
            if (full_tail) begin
              last_d     = 1'b0;
              pad_pend_d = 1'b1;
            end else begin
              acc_d  = acc_d ^ pad_vec;
              last_d = 1'b1;
            end
          end else if (lane_cnt_q == LAST_LANE) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
          end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
          end
        end
      end
      ST_EMIT: begin
        if (blk_ready) begin
          acc_d      = '0;
          lane_cnt_d = '0;
          last_d     = 1'b0;
          state_d    = pad_pend_q ? ST_EXTRA : ST_FILL;
        end
      end
      ST_EXTRA: begin
        if (blk_ready) begin
          pad_pend_d = 1'b0;
          state_d    = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase

    if (init) begin
      state_d    = ST_FILL;
      acc_d      = '0;
      lane_cnt_d = '0;
      pad_pend_d = 1'b0;
      last_d     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      acc_q      <= '0;
      lane_cnt_q <= '0;
      pad_pend_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      lane_cnt_q <= lane_cnt_d;
      pad_pend_q <= pad_pend_d;
      last_q     <= last_d;
    end
  end

  // Outputs decode from registered state only, so there is no
  // combinational path from either valid to either ready.
  assign msg_ready = (state_q == ST_FILL);
  assign blk_valid = (state_q == ST_EMIT) || (state_q == ST_EXTRA);
  assign blk_data  = (state_q == ST_EMIT)  ? acc_q :
                     (state_q == ST_EXTRA) ? EXTRA_BLK : '0;
  assign blk_last  = (state_q == ST_EMIT)  ? last_q : (state_q == ST_EXTRA);
  assign busy      = (state_q != ST_FILL) || (lane_cnt_q != '0);

endmodule

// File: tb/tb_shake128_block_packer.sv
// Scoreboard bench for shake128_block_packer: a byte-level SHAKE padding
// model predicts every block; a monitor compares blocks on handshake.
module tb_shake128_block_packer;

  localparam int RATE  = 1344;
  localparam int BYTES = RATE / 8;

`ifdef SHAKE_PACK_SHA3_DS_EN
  localparam logic [7:0] DS = 8'h06;
`else
  localparam logic [7:0] DS = 8'h1F;
`endif

  logic            clk;
  logic            rst_n;
  logic            init;
  logic            msg_valid;
  logic [63:0]     msg_data;
  logic            msg_last;
  logic [3:0]      msg_bytes;
  logic            msg_ready;
  logic            blk_valid;
  logic [RATE-1:0] blk_data;
  logic            blk_last;
  logic            blk_ready = 1'b0;
  logic            busy;

  shake128_block_packer #(.RATE(RATE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .msg_valid (msg_valid),
    .msg_data  (msg_data),
    .msg_last  (msg_last),
    .msg_bytes (msg_bytes),
    .msg_ready (msg_ready),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_last  (blk_last),
    .blk_ready (blk_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [RATE-1:0] exp_data_q[$];
  logic            exp_last_q[$];
  logic [7:0]      mq[$];

  bit   rand_ready = 1'b0;
  logic ready_hold = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input string name, input logic [RATE-1:0] act, input logic [RATE-1:0] exp);
    int first;
    first = 0;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < BYTES; k++) begin
        if (act[8*k +: 8] !== exp[8*k +: 8]) begin
          first = k;
          break;
        end
      end
      $display("FAIL %s: byte %0d got %h expected %h", name, first,
               act[8*first +: 8], exp[8*first +: 8]);
    end
  endtask

  // Reference: append domain byte, zero-fill to a whole number of blocks,
  // set the top bit of the final byte, then cut into blocks.
  task automatic build_expected();
    logic [7:0]      p[$];
    logic [RATE-1:0] v;
    int              nblk;
    p = mq;
    p.push_back(DS);
    while ((p.size() % BYTES) != 0) p.push_back(8'h00);
    p[p.size()-1] = p[p.size()-1] ^ 8'h80;
    nblk = p.size() / BYTES;
    for (int b = 0; b < nblk; b++) begin
      v = '0;
      for (int k = 0; k < BYTES; k++) v[8*k +: 8] = p[b*BYTES + k];
      exp_data_q.push_back(v);
      exp_last_q.push_back(b == nblk - 1);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
    int cnt;
    cnt       = 0;
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = l;
    msg_bytes = nb;
    @(negedge clk);
    while (!msg_ready && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    if (!msg_ready) begin
      checks++;
      errors++;
      $display("FAIL msg_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic send_msg(input bit gaps);
    int          nw;
    int          idx;
    int          nb;
    logic [63:0] d;
    logic [3:0]  bf;
    build_expected();
    nw = (mq.size() == 0) ? 1 : (mq.size() + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      for (int k = 0; k < 8; k++) begin
        idx = 8*w + k;
        d[8*k +: 8] = (idx < mq.size()) ? mq[idx] : 8'($urandom);
      end
      if (w == nw - 1) begin
        nb = mq.size() - 8*w;
        bf = (nb == 8) ? 4'($urandom_range(8, 15)) : 4'(nb);
      end else begin
        bf = 4'($urandom);
      end
      drive_word(d, (w == nw - 1), bf);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic fill_random(input int len);
    mq.delete();
    for (int i = 0; i < len; i++) mq.push_back(8'($urandom));
  endtask

  task automatic wait_drain(input int budget);
    int cnt;
    cnt = 0;
    while (exp_data_q.size() != 0 && cnt < budget) begin
      cnt++;
      @(negedge clk);
    end
    chk("drain_pending", 64'(exp_data_q.size()), 64'd0);
  endtask

  task automatic settle_and_stall();
    @(posedge clk);
    #2;
    ready_hold = 1'b0;
    @(posedge clk);
    #2;
  endtask

  // blk_ready is owned by this process alone; changes land just after an edge.
  always @(posedge clk) begin
    #1;
    blk_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  // Monitor: pops expectations on handshakes and checks hold stability.
  logic            prev_hold = 1'b0;
  logic [RATE-1:0] prev_data = '0;
  logic            prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(blk_valid), 64'd1);
        chk_blk("hold_data", blk_data, prev_data);
        chk("hold_last", 64'(blk_last), 64'(prev_last));
      end
      if (blk_valid && blk_ready && !init) begin
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got block expected none");
        end else begin
          logic [RATE-1:0] e;
          logic            l;
          e = exp_data_q.pop_front();
          l = exp_last_q.pop_front();
          chk_blk("blk_data", blk_data, e);
          chk("blk_last", 64'(blk_last), 64'(l));
        end
      end
      prev_hold = blk_valid && !blk_ready && !init;
      prev_data = blk_data;
      prev_last = blk_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;
    rst_n     = 1'b0;
    init      = 1'b0;
    msg_valid = 1'b0;
    msg_data  = '0;
    msg_last  = 1'b0;
    msg_bytes = '0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_msg_ready", 64'(msg_ready), 64'd1);
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk_blk("rst_blk_data", blk_data, '0);
    chk("rst_blk_last", 64'(blk_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    // Empty message.
    mq.delete();
    chk("empty_pre_valid", 64'(blk_valid), 64'd0);
    send_msg(1'b0);
    chk("empty_lat_valid", 64'(blk_valid), 64'd1);
    chk("empty_msg_ready", 64'(msg_ready), 64'd0);
    chk("empty_byte0", 64'(blk_data[7:0]), 64'(DS));
    chk("empty_byte167", 64'(blk_data[RATE-1 -: 8]), 64'h80);
    chk("empty_last", 64'(blk_last), 64'd1);
    ready_hold = 1'b1;
    wait_drain(50);
    @(posedge clk);
    #2;
    chk("post_hs_msg_ready", 64'(msg_ready), 64'd1);
    chk("post_hs_busy", 64'(busy), 64'd0);
    settle_and_stall();

    // "abc".
    mq = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    chk("abc_low", 64'(blk_data[31:0]), 64'({DS, 24'h636261}));
    chk("abc_byte167", 64'(blk_data[RATE-1 -: 8]), 64'h80);
    ready_hold = 1'b1;
    wait_drain(50);
    settle_and_stall();

    // 167 bytes: domain byte and end bit share the final byte.
    fill_random(167);
    send_msg(1'b0);
    chk("m167_byte167", 64'(blk_data[RATE-1 -: 8]), 64'(DS ^ 8'h80));
    chk("m167_last", 64'(blk_last), 64'd1);
    ready_hold = 1'b1;
    wait_drain(50);
    settle_and_stall();

    // 168 bytes: message block then a pad-only block.
    fill_random(168);
    send_msg(1'b0);
    chk("m168_last0", 64'(blk_last), 64'd0);
    ready_hold = 1'b1;
    wait_drain(50);
    settle_and_stall();

    // Backpressure then init.
    fill_random(40);
    send_msg(1'b0);
    prev_data = blk_data;
    begin
      logic [RATE-1:0] cap;
      cap = blk_data;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("bp_valid", 64'(blk_valid), 64'd1);
        chk_blk("bp_data", blk_data, cap);
        chk("bp_msg_ready", 64'(msg_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
      end
    end
    @(posedge clk);
    #2;
    init = 1'b1;
    @(posedge clk);
    #2;
    init = 1'b0;
    chk("init_valid", 64'(blk_valid), 64'd0);
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_msg_ready", 64'(msg_ready), 64'd1);
    chk_blk("init_data", blk_data, '0);
    exp_data_q.delete();
    exp_last_q.delete();

    // Async reset after 5 words, then "abc" again.
    for (int i = 0; i < 5; i++) drive_word({$urandom, $urandom}, 1'b0, 4'd0);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("ar_msg_ready", 64'(msg_ready), 64'd1);
    chk("ar_blk_valid", 64'(blk_valid), 64'd0);
    chk_blk("ar_blk_data", blk_data, '0);
    chk("ar_blk_last", 64'(blk_last), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    mq = '{8'h61, 8'h62, 8'h63};
    send_msg(1'b0);
    chk("abc2_low", 64'(blk_data[31:0]), 64'({DS, 24'h636261}));
    ready_hold = 1'b1;
    wait_drain(50);
    settle_and_stall();

    // Randomised traffic with random backpressure and input gaps.
    rand_ready = 1'b1;
    for (int m = 0; m < 25; m++) begin
      case ($urandom_range(0, 5))
        0:       len = 168 * $urandom_range(1, 2);
        1:       len = 168 * $urandom_range(1, 2) - 1;
        2:       len = 8 * $urandom_range(0, 30);
        default: len = $urandom_range(0, 400);
      endcase
      fill_random(len);
      send_msg(1'b1);
    end
    wait_drain(5000);
    rand_ready = 1'b0;
    ready_hold = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("final_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
